// File: rtl/dbus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dbus_arbiter_pkg
// Shared data-bus types used by the data-bus arbiter and its neighbours.
// The request/response structs match the core's common bus definitions.
// The arbiter state enum lives here so the testbench and the top can share it.
//
// Contents:
//   addr_t / word_t / msize_t / strobe_t  basic bus field types
//   dbus_req_t        request from a requester to the bus
//   dbus_resp_t       response from the bus to a requester
//   dbus_arb_state_t  IDLE / BUSY state of the arbiter
// ---------------------------------------------------------------------------
package dbus_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [2:0]  msize_t;
  typedef logic [3:0]  strobe_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dbus_arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way pick used by the data-bus arbiter while it is idle.
// A lone requester always wins. When both ports request, the preferred port
// (rr) wins.
//
// Ports:
//   v0, v1       request valid from port 0 / port 1
//   rr           preferred port when both request
//   grant_valid  at least one port is requesting
//   grant_id     winning port (0 when nobody requests)
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic v0,
  input  logic v1,
  input  logic rr,
  output logic grant_valid,
  output logic grant_id
);

  // A contested pick follows the preference bit. Otherwise port 1 wins only
  // when it is the sole requester.
  assign grant_valid = v0 | v1;
  assign grant_id    = (v0 & v1) ? rr : v1;

endmodule

// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter
// Shares the single data bus between the MEM-stage access unit (port 0) and
// the page-table walker (port 1). A requester holds the bus from its first
// cycle until data_ok. Grants alternate round-robin. The port that is not
// using the bus sees an all-zero response. The arbiter also counts completed
// transactions per port and keeps a sticky protocol-error flag.
//
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   req0, resp0  port 0 (MEM stage) request / response
//   req1, resp1  port 1 (page-table walker) request / response
//   dreq, dresp  request to / response from the shared data bus
//   busy         registered: the bus is locked to owner
//   owner        registered: lock holder, meaningful only while busy
//   done_cnt0/1  completed transactions per port, wrap-around
//   proto_err    sticky: an owner dropped valid before data_ok
// ---------------------------------------------------------------------------
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  dbus_req_t        req0,
  output dbus_resp_t       resp0,
  input  dbus_req_t        req1,
  output dbus_resp_t       resp1,
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1,
  output logic             proto_err
);

  dbus_arb_state_t  state;
  logic             owner_q;
  logic             rr_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
  logic             err_q;

  logic      pick_valid;
  logic      pick_id;
  logic      sel_valid;
  logic      sel_id;
  dbus_req_t sel_req;
  logic      complete;

  rr_pick2 u_pick (
    .v0          (req0.valid),
    .v1          (req1.valid),
    .rr          (rr_q),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  // Decide which port drives the bus this cycle. While locked, the owner keeps
  // the bus even if it drops valid, so a protocol error cannot hand the bus to
  // the other port. While idle, the round-robin pick is used directly, so a
  // request needs no extra cycle. Holding reset forces "nobody", so the bus
  // and both responses go quiet at once, even if a requester still drives valid.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 1'b0;
    if (rst) begin
      if (state == BUSY) begin
        sel_valid = 1'b1;
        sel_id    = owner_q;
      end else begin
        sel_valid = pick_valid;
        sel_id    = pick_id;
      end
    end
  end

  // Steer the selected request to the bus and the bus response back to the
  // selected port only. The other port sees all zeros, so its addr_ok and
  // data_ok stay low.
  assign sel_req  = sel_id ? req1 : req0;
  assign dreq     = sel_valid ? sel_req : '0;
  assign resp0    = (sel_valid && !sel_id) ? dresp : '0;
  assign resp1    = (sel_valid &&  sel_id) ? dresp : '0;
  assign complete = sel_valid && dresp.data_ok;

  // Lock state, round-robin preference, completion counters and error flag.
  // A completion always returns to IDLE and hands preference to the other
  // port. Any selected cycle without data_ok locks the bus to the selected
  // port. Only the locked owner can trigger a protocol error, by dropping
  // valid before data_ok.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (complete) begin
        state <= IDLE;
        rr_q  <= ~sel_id;
        if (sel_id) begin
          cnt1_q <= cnt1_q + CNT_W'(1);
        end else begin
          cnt0_q <= cnt0_q + CNT_W'(1);
        end
      end else if (sel_valid) begin
        state   <= BUSY;
        owner_q <= sel_id;
        if ((state == BUSY) && !sel_req.valid) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state == BUSY);
  assign owner     = owner_q;
  assign done_cnt0 = cnt0_q;
  assign done_cnt1 = cnt1_q;
  assign proto_err = err_q;

endmodule
